// File: rtl/alu_pkg.sv
// alu_pkg: ALU function/mode encodings and sequencer state type shared by alu16_seq and its peers.
package alu_pkg;
  localparam logic [1:0] ALU_NOT = 2'b00, ALU_AND = 2'b01, ALU_OR = 2'b10, ALU_XOR = 2'b11;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01;
  localparam logic MODE_LOGIC = 1'b0, MODE_ARITH = 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu16_seq.sv
// alu16_seq: runs 4*NIBBLES-bit ops through an external 4-bit ALU one nibble per cycle, LSB first.
// Define ALU16_SEQ_OVF_EN to add the signed-overflow output out_ovf.
module alu16_seq
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
  input  logic [1:0]             in_s,
  input  logic                   in_m,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_cin,
  output logic [1:0]             alu_s,
  output logic                   alu_m,
  input  logic [3:0]             alu_f,
  input  logic                   alu_cn,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_f,
  output logic                   out_cn,
  output logic                   out_zero
`ifdef ALU16_SEQ_OVF_EN
  ,
  output logic                   out_ovf
`endif
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    a_q, b_q, res_q;
  logic [1:0]      s_q;
  logic            m_q, carry_q;
  logic            run, done;
  assign run       = state_q == RUN;
  assign done      = state_q == DONE;
  assign in_ready  = state_q == IDLE;
  assign out_valid = done;
  assign alu_a     = run ? a_q[4*idx_q +: 4] : 4'h0;
  assign alu_b     = run ? b_q[4*idx_q +: 4] : 4'h0;
  assign alu_cin   = run && carry_q;
  assign alu_s     = run ? s_q : 2'b00;
  assign alu_m     = run && m_q;
  assign out_f     = done ? res_q : '0;
  assign out_cn    = done && carry_q;
  assign out_zero  = done && (res_q == '0);
`ifdef ALU16_SEQ_OVF_EN
  logic sa, sb, sf;
  assign sa = a_q[W-1];
  assign sb = b_q[W-1];
  assign sf = res_q[W-1];
  assign out_ovf = done && (m_q == MODE_ARITH) &&
                   ((s_q == ALU_ADD) ? (sa == sb) && (sf != sa) :
                    (s_q == ALU_SUB) ? (sa != sb) && (sf != sa) : 1'b0);
`endif
  // carry_q is seeded with in_cin so nibble 0 and later nibbles share one alu_cin path
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= in_a;
          b_q     <= in_b;
          s_q     <= in_s;
          m_q     <= in_m;
          carry_q <= in_cin;
          idx_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          res_q[4*idx_q +: 4] <= alu_f;
          carry_q <= alu_cn;
          idx_q   <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
          if (idx_q == LAST) state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu16_seq.sv
// tb_alu16_seq: directed bench for alu16_seq with a 4-bit reference ALU and a whole-word result model.
module tb_alu16_seq;
  import alu_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_cin = 1'b0, in_m = 1'b0;
  logic [15:0] in_a = '0, in_b = '0, out_f;
  logic [1:0] in_s = 2'b00, alu_s;
  logic [3:0] alu_a, alu_b, alu_f;
  logic alu_cin, alu_m, alu_cn;
  logic out_valid, out_ready = 1'b1, out_cn, out_zero;
`ifdef ALU16_SEQ_OVF_EN
  logic out_ovf;
`endif
  int tests = 0, fails = 0, since = -1;
  logic [16:0] exp_r = '0;
  logic [15:0] exp_a = '0, exp_b = '0;
  logic [4:0] alu_t;
  always #5 clk = ~clk;
  alu16_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_s(in_s), .in_m(in_m),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_s(alu_s), .alu_m(alu_m),
    .alu_f(alu_f), .alu_cn(alu_cn), .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_cn(out_cn), .out_zero(out_zero)
`ifdef ALU16_SEQ_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );
  // reference 4-bit ALU peer
  always_comb begin
    alu_t = '0;
    if (alu_m == MODE_LOGIC)
      alu_t = {1'b0, alu_s == ALU_NOT ? ~alu_a : alu_s == ALU_AND ? (alu_a & alu_b) :
                     alu_s == ALU_OR ? (alu_a | alu_b) : (alu_a ^ alu_b)};
    else if (alu_s == ALU_ADD) alu_t = 5'(alu_a) + 5'(alu_b) + 5'(alu_cin);
    else if (alu_s == ALU_SUB) alu_t = 5'(alu_a) - 5'(alu_b) - 5'(alu_cin);
  end
  assign alu_f  = alu_t[3:0];
  assign alu_cn = alu_t[4];
  function automatic logic [16:0] model(input logic [15:0] a, b, input logic cin, input logic [1:0] s, input logic m);
    if (m == MODE_LOGIC)
      return {1'b0, s == ALU_NOT ? ~a : s == ALU_AND ? (a & b) : s == ALU_OR ? (a | b) : (a ^ b)};
    if (s == ALU_ADD) return 17'(a) + 17'(b) + 17'(cin);
    if (s == ALU_SUB) return 17'(a) - 17'(b) - 17'(cin);
    return '0;
  endfunction
  function automatic logic ovf_model(input logic [15:0] a, b, f, input logic [1:0] s, input logic m);
    if (m != MODE_ARITH) return 1'b0;
    if (s == ALU_ADD) return (a[15] == b[15]) && (f[15] != a[15]);
    if (s == ALU_SUB) return (a[15] != b[15]) && (f[15] != a[15]);
    return 1'b0;
  endfunction
  logic [1:0] exp_s = '0;
  logic exp_m = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  // cycle monitor: since = edges since acceptance, -1 when idle
  always @(negedge clk) begin
    if (rst) begin
      since = -1;
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_f", 32'(out_f), 32'd0);
      chk("rst_cn_zero", {out_cn, out_zero}, 32'd0);
      chk("rst_alu", {alu_a, alu_b, alu_cin, alu_s, alu_m}, 32'd0);
    end else begin
      chk("ready", 32'(in_ready), 32'(since < 0));
      chk("valid", 32'(out_valid), 32'(since >= N));
      chk("out_f", 32'(out_f), since >= N ? 32'(exp_r[15:0]) : 32'd0);
      chk("out_cn", 32'(out_cn), since >= N ? 32'(exp_r[16]) : 32'd0);
      chk("out_zero", 32'(out_zero), 32'(since >= N && exp_r[15:0] == 16'h0));
`ifdef ALU16_SEQ_OVF_EN
      chk("out_ovf", 32'(out_ovf), since >= N ? 32'(ovf_model(exp_a, exp_b, exp_r[15:0], exp_s, exp_m)) : 32'd0);
`endif
      if (since >= 0 && since < N) begin
        chk("alu_a", 32'(alu_a), 32'(exp_a[4*since +: 4]));
        chk("alu_b", 32'(alu_b), 32'(exp_b[4*since +: 4]));
        chk("alu_sm", {alu_s, alu_m}, {exp_s, exp_m});
      end else chk("alu_idle", {alu_a, alu_b, alu_cin, alu_s, alu_m}, 32'd0);
      if (since < 0) begin
        if (in_valid) begin
          since = 0;
          exp_r = model(in_a, in_b, in_cin, in_s, in_m);
          exp_a = in_a;
          exp_b = in_b;
          exp_s = in_s;
          exp_m = in_m;
        end
      end else if (since < N) since++;
      else if (out_ready) since = -1;
    end
  end
  task automatic wait_valid(input string nm, input int lat);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (lat > 0) chk({nm, "_lat"}, 32'(n), 32'(lat));
    else chk({nm, "_seen"}, 32'(out_valid), 32'd1);
  endtask
  task automatic op(input string nm, input logic [15:0] a, b, input logic cin, input logic m,
                    input logic [1:0] s, input logic [15:0] ef, input logic ecn, input logic eovf);
    in_a = a; in_b = b; in_cin = cin; in_m = m; in_s = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom); in_cin = ~cin; in_s = ~s; in_m = ~m;
    wait_valid(nm, N);
    chk({nm, "_f"}, 32'(out_f), 32'(ef));
    chk({nm, "_cn"}, 32'(out_cn), 32'(ecn));
    chk({nm, "_zero"}, 32'(out_zero), 32'(ef == 16'h0));
`ifdef ALU16_SEQ_OVF_EN
    chk({nm, "_ovf"}, 32'(out_ovf), 32'(eovf));
`else
    if (eovf === 1'bx) chk({nm, "_ovf_arg"}, 32'(eovf), 32'd0);
`endif
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, MODE_ARITH, ALU_ADD, 16'h0000, 1'b1, 1'b0);
    op("sub_borrow", 16'h0000, 16'h0001, 1'b0, MODE_ARITH, ALU_SUB, 16'hFFFF, 1'b1, 1'b0);
    op("sub_chain", 16'h1234, 16'h0235, 1'b0, MODE_ARITH, ALU_SUB, 16'h0FFF, 1'b0, 1'b0);
    op("xor", 16'hF0F0, 16'hFF00, 1'b0, MODE_LOGIC, ALU_XOR, 16'h0FF0, 1'b0, 1'b0);
    op("and", 16'hF0F0, 16'hFF00, 1'b1, MODE_LOGIC, ALU_AND, 16'hF000, 1'b0, 1'b0);
    op("or", 16'h0F0F, 16'h00F0, 1'b0, MODE_LOGIC, ALU_OR, 16'h0FFF, 1'b0, 1'b0);
    op("not", 16'h1234, 16'hAAAA, 1'b0, MODE_LOGIC, ALU_NOT, 16'hEDCB, 1'b0, 1'b0);
    op("arith_s10", 16'h1234, 16'h5678, 1'b1, MODE_ARITH, 2'b10, 16'h0000, 1'b0, 1'b0);
    op("arith_s11", 16'hFFFF, 16'hFFFF, 1'b1, MODE_ARITH, 2'b11, 16'h0000, 1'b0, 1'b0);
    op("add_cin", 16'h1234, 16'h0FFF, 1'b1, MODE_ARITH, ALU_ADD, 16'h2234, 1'b0, 1'b0);
    op("sub_cin", 16'h0005, 16'h0003, 1'b1, MODE_ARITH, ALU_SUB, 16'h0001, 1'b0, 1'b0);
    op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, MODE_ARITH, ALU_ADD, 16'h8000, 1'b0, 1'b1);
    op("ovf_sub", 16'h8000, 16'h0001, 1'b0, MODE_ARITH, ALU_SUB, 16'h7FFF, 1'b0, 1'b1);
    // backpressure with a second request waiting
    out_ready = 1'b0;
    in_a = 16'hF0F0; in_b = 16'h0F0F; in_cin = 1'b0; in_m = MODE_ARITH; in_s = ALU_ADD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid("bp", N);
    in_a = 16'h0001; in_b = 16'h0002; in_valid = 1'b1;
    repeat (10) begin
      chk("bp_f", 32'(out_f), 32'h0000FFFF);
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("pend_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pend_taken", 32'(in_ready), 32'd0);
    wait_valid("pend", 0);
    chk("pend_f", 32'(out_f), 32'h00000003);
    @(posedge clk); #1;
    // reset in the middle of an add
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_m = MODE_ARITH; in_s = ALU_ADD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_alu", {alu_a, alu_b}, 32'h12);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out", {out_valid, out_cn, out_zero, out_f}, 32'd0);
    chk("mid_rst_alu", {alu_a, alu_b, alu_cin, alu_s, alu_m}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    op("after_rst", 16'h1111, 16'h2222, 1'b0, MODE_ARITH, ALU_ADD, 16'h3333, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
